// File: rtl/oh_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// an index-width helper that never returns less than one bit.
package oh_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Width of an index into n items; at least one bit even for n <= 2.
    function automatic int idx_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/oh_rr_pick.sv
// Combinational rotating-priority picker. The request vector is doubled so
// that a single upward search starting at ptr_i covers ptr..N-1 then 0..ptr-1.
module oh_rr_pick
    import oh_arb_pkg::*;
#(
    parameter int N    = 3,
    parameter     PROP = "DEFAULT",
    localparam int IW  = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_oh_o,
    output logic [IW-1:0] win_idx_o,
    output logic          any_o
);

    localparam int SW = IW + 1;

    logic [2*N-1:0] dbl_req;
    logic [N-1:0]   rot_req;
    logic           hit;
    int unsigned    hit_off;
    logic [SW-1:0]  sum_idx;

    // The property string selects no alternate implementation today.
    if (PROP == "") begin : g_prop_empty
    end

    assign dbl_req = {req_i, req_i};
    assign rot_req = dbl_req[ptr_i +: N];
    assign any_o   = |req_i;

    // Find the first set bit of the rotated vector and map it back to an index.
    always_comb begin
        hit     = 1'b0;
        hit_off = 0;
        for (int j = 0; j < N; j++) begin
            if (!hit && rot_req[j]) begin
                hit     = 1'b1;
                hit_off = j;
            end
        end
        sum_idx = {1'b0, ptr_i} + SW'(hit_off);
        if (sum_idx >= SW'(N)) begin
            sum_idx = sum_idx - SW'(N);
        end
        win_idx_o = sum_idx[IW-1:0];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_oh
        assign win_oh_o[gi] = any_o && (win_idx_o == IW'(gi));
    end

endmodule

// File: rtl/oh_rrarb.sv
// Round-robin arbiter with a registered one-hot grant held until the owner
// signals done or drops its request. Optional hold-time limit is compiled in
// with the macro OH_RRARB_TIMEOUT_EN.
module oh_rrarb
    import oh_arb_pkg::*;
#(
    parameter int N       = 3,
    parameter int TIMEOUT = 16,
    parameter     PROP    = "DEFAULT",
    localparam int IW     = idx_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req0,
    input  logic [N-1:0]  req1,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] owner,
    output logic          busy,
    output logic          timeout
);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  ereq;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic          rel_norm;
    logic          rel;

    // Illegal parameter combinations leave a visible marker in the hierarchy.
    if (N < 2 || TIMEOUT < 2) begin : g_bad_params
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ereq
        assign ereq[gi] = req0[gi] | req1[gi];
    end

    assign next_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
    assign rel_norm = done[owner_q] | ~ereq[owner_q];

`ifdef OH_RRARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          force_rel;

    assign force_rel = (cnt_q == CW'(TIMEOUT - 1)) & ~rel_norm;
    assign rel       = rel_norm | force_rel;
    assign timeout   = timeout_q;
`else
    assign rel     = rel_norm;
    assign timeout = 1'b0;
`endif

    // On release, re-arbitrate against the advanced pointer in the same cycle.
    assign pick_ptr = (state_q == ST_OWN) ? next_ptr : ptr_q;

    oh_rr_pick #(
        .N    (N),
        .PROP (PROP)
    ) u_pick (
        .req_i     (ereq),
        .ptr_i     (pick_ptr),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    // Next-state: grant on request from idle, hold or hand over on release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef OH_RRARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_OWN;
                    grant_d = win_oh;
                    owner_d = win_idx;
`ifdef OH_RRARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ST_OWN: begin
`ifdef OH_RRARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                if (rel) begin
                    ptr_d = next_ptr;
`ifdef OH_RRARB_TIMEOUT_EN
                    timeout_d = force_rel;
`endif
                    if (win_any) begin
                        grant_d = win_oh;
                        owner_d = win_idx;
`ifdef OH_RRARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset wins over any grant in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef OH_RRARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef OH_RRARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = (state_q == ST_OWN);

endmodule

// File: tb/tb_oh_rrarb.sv
// Scoreboard bench for oh_rrarb: each stimulus cycle pushes the response a
// behavioural round-robin model predicts; a negedge monitor pops and compares.
module tb_oh_rrarb;

    localparam int N  = 3;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req0 = '0;
    logic [N-1:0] req1 = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         busy;
    logic         timeout;

    always #5 clk = ~clk;

    oh_rrarb #(
        .N       (N),
        .TIMEOUT (TO),
        .PROP    ("DEFAULT")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .done    (done),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic         busy;
        int           owner;
        bit           chk_owner;
        logic         to;
        int           seq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   seq_no = 0;

    // Reference model: who holds the resource, where the search starts next,
    // and how many cycles the current holder has already had.
    bit m_busy = 1'b0;
    int m_own  = 0;
    int m_ptr  = 0;
    int m_held = 0;

    function automatic int find_winner(input logic [N-1:0] e, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (e[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] owner_done();
        logic [N-1:0] v;
        v = '0;
        if (m_busy) v[m_own] = 1'b1;
        return v;
    endfunction

    task automatic model_push(input logic [N-1:0] r0, input logic [N-1:0] r1,
                              input logic [N-1:0] d, input logic rst);
        logic [N-1:0] e;
        logic [N-1:0] g;
        int   w;
        bit   released;
        bit   forced;
        exp_t x;
        e      = r0 | r1;
        forced = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_own  = 0;
            m_ptr  = 0;
            m_held = 0;
        end else if (!m_busy) begin
            w = find_winner(e, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_own  = w;
                m_held = 0;
            end
        end else begin
            released = d[m_own] || !e[m_own];
`ifdef OH_RRARB_TIMEOUT_EN
            // The holder has used its whole allowance after this cycle.
            forced = !released && (m_held + 1 >= TO);
`endif
            m_held++;
            if (released || forced) begin
                m_ptr = (m_own + 1) % N;
                w = find_winner(e, m_ptr);
                if (w >= 0) begin
                    m_own  = w;
                    m_held = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        g = '0;
        if (m_busy) g[m_own] = 1'b1;
        x.grant     = g;
        x.busy      = m_busy;
        x.owner     = m_own;
        x.chk_owner = m_busy || rst;
        x.to        = forced;
        x.seq       = seq_no;
        seq_no++;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [N-1:0] r0, input logic [N-1:0] r1,
                         input logic [N-1:0] d, input logic rst);
        @(negedge clk);
        #1;
        req0  = r0;
        req1  = r1;
        done  = d;
        reset = rst;
        model_push(r0, r1, d, rst);
    endtask

    // Monitor: outputs updated at the previous posedge are compared here.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (grant !== mon_e.grant) begin
                errors++;
                $display("FAIL grant txn %0d: got %b expected %b", mon_e.seq, grant, mon_e.grant);
            end
            checks++;
            if (busy !== mon_e.busy) begin
                errors++;
                $display("FAIL busy txn %0d: got %b expected %b", mon_e.seq, busy, mon_e.busy);
            end
            checks++;
            if (timeout !== mon_e.to) begin
                errors++;
                $display("FAIL timeout txn %0d: got %b expected %b", mon_e.seq, timeout, mon_e.to);
            end
            if (mon_e.chk_owner) begin
                checks++;
                if (int'(owner) !== mon_e.owner) begin
                    errors++;
                    $display("FAIL owner txn %0d: got %0d expected %0d", mon_e.seq, owner, mon_e.owner);
                end
            end
            $display("txn %0d grant=%b busy=%b owner=%0d timeout=%b", mon_e.seq, grant, busy, owner, timeout);
        end
    end

    initial begin
        // Reset state.
        drive('0, '0, '0, 1'b1);
        drive('0, '0, '0, 1'b1);

        // Reset in the middle of a grant to requester 1, then fresh requests.
        repeat (3) drive(3'b010, '0, '0, 1'b0);
        drive(3'b010, '0, '0, 1'b1);
        repeat (2) drive(3'b111, '0, '0, 1'b0);

        // Fairness: everyone requests, the owner releases each cycle.
        drive('0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) drive('0, 3'b111, owner_done(), 1'b0);
        drive('0, '0, '0, 1'b0);

        // Wrap and drop: release by 1 moves the search start to 2.
        drive('0, '0, '0, 1'b1);
        drive('0, 3'b010, '0, 1'b0);
        drive('0, 3'b011, 3'b010, 1'b0);
        drive('0, 3'b011, '0, 1'b0);
        drive('0, 3'b010, '0, 1'b0);
        drive('0, 3'b010, '0, 1'b0);

        // done from non-owners has no effect; then owner leaves and bus idles.
        drive('0, '0, '0, 1'b1);
        drive(3'b001, '0, '0, 1'b0);
        repeat (5) drive(3'b001, '0, 3'b110, 1'b0);
        drive('0, '0, 3'b001, 1'b0);
        drive('0, '0, '0, 1'b0);

        // Requester 2 never lets go while requester 0 waits.
        drive('0, '0, '0, 1'b1);
        drive(3'b100, '0, '0, 1'b0);
        repeat (100) drive(3'b101, '0, '0, 1'b0);

        // Random traffic with sparse done pulses and rare resets.
        drive('0, '0, '0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] r0;
            logic [N-1:0] r1;
            logic [N-1:0] d;
            logic         rs;
            r0 = N'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            d  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            rs = ($urandom_range(0, 199) == 0);
            drive(r0, r1, d, rs);
        end
        drive('0, '0, '0, 1'b0);
        drive('0, '0, '0, 1'b0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never compared, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oh_rrarb.md
Name: oh_rrarb

Overview:
- Round-robin arbiter that shares one resource between N requesters.
- Each requester presents two request sources, which are OR-combined in the same way as the or-and gate input pairs.
- Issues a registered one-hot grant. The grant is held until the owner signals done or drops its request.
- Sits in front of shared asiclib datapaths such as muxed buses and shared gate or cell banks.

Parameters:
- N, 3, number of requesters; legal range N>=2.
- TIMEOUT, 16, maximum cycles a grant may be held; used only when the optional feature is compiled in; legal range >=2.
- PROP, "DEFAULT", implementation property string, passed through to sub-modules.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  N  request source 0, one bit per requester.
- req1  input  N  request source 1, one bit per requester.
- done  input  N  release strobe, one bit per requester; sampled only for the current owner.
- grant  output  N  registered one-hot grant; all-zero when idle.
- owner  output  $clog2(N)  index of the current owner; valid only while busy=1.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Effective request: ereq[i] = req0[i] | req1[i].
- Reset (clk edge with reset=1) forces: grant=0, owner=0, busy=0, timeout=0, ptr=0, state=IDLE. Reset takes priority over every other event, including mid-grant.
- ptr is the rotating priority pointer. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- State IDLE:
  - If any ereq is high, pick the first high bit in search order.
  - Next edge: grant[win]=1, owner=win, busy=1, state=OWN.
  - Request-to-grant latency is 1 cycle.
- State OWN (owner k), release condition: rel = done[k] | ~ereq[k] (| timeout expiry, if the optional feature is enabled).
- OWN with rel=0: grant held unchanged. done[j] for j!=k is ignored.
- OWN with rel=1:
  - ptr <= (k+1) mod N, wrapping from N-1 to 0.
  - Arbitration reruns in the same cycle using the new ptr. Requester k is therefore lowest priority.
  - If any ereq remains high (k's own ereq included), the next edge grants the winner back-to-back, with no idle cycle.
  - If none remain, the next edge clears grant, sets busy=0 and state=IDLE.
- No grant change occurs without rel; new requests never preempt the owner.
- grant is always one-hot or zero; owner is stable for the full grant.
- Simultaneous done[k] and a deasserted ereq[k] count as a single release.

Optional Feature:
- Macro OH_RRARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit hold counter clears on every new grant, including back-to-back grants, and increments each cycle in OWN.
  - When the counter reaches TIMEOUT-1 with no other release, a forced release occurs. The grant therefore lasts exactly TIMEOUT cycles.
  - timeout pulses high for one cycle, coincident with the cycle grant changes or drops.
  - ptr advances as for a normal release.
- Undefined: no counter; timeout is tied to 0; TIMEOUT is unused.

Decomposition:
- Package oh_arb_pkg:
  - state encodings ST_IDLE=1'b0, ST_OWN=1'b1;
  - an index-width helper function (clog2 with a minimum of 1).
- Sub-module oh_rr_pick, combinational:
  - inputs req[N-1:0] and ptr;
  - outputs a one-hot winner, its index, and an any flag;
  - implemented as a doubled-vector priority search.
- All registers live in oh_rrarb.

Test Plan:
- Reset mid-grant: N=3, grant=3'b010 held, assert reset one cycle -> next edge grant=0, busy=0, owner=0; then req0=3'b111 -> grant=3'b001 one cycle later.
- Fairness: req1=3'b111 held, pulse done for each owner -> grant sequence 001,010,100,001, each back-to-back with busy staying 1.
- Wrap and drop: ptr=2 after requester 1 releases, ereq=3'b011 -> grant=3'b001 (index 2 skipped, search wraps to 0). Drop req of owner 0 -> grant=3'b010 next edge.
- Non-owner done ignored: owner=0, done=3'b110 for 5 cycles -> grant stays 3'b001. Requests cleared plus done[0] -> grant=0, busy=0 next edge.
- Timeout (OH_RRARB_TIMEOUT_EN, TIMEOUT=4): requester 2 holds its request without done, requester 0 also requesting -> grant=3'b100 for exactly 4 cycles, timeout=1 for one cycle, then grant=3'b001.
- Timeout compiled out: same stimulus -> grant=3'b100 held for 100 cycles, timeout stays 0.
